// File: rtl/rtu_arbiter.sv
// rtu_arbiter: two-requester round-robin front end for a shared
// reverse_transform_unit. It latches the granted 6x6 tile, starts the RTU,
// captures the 4x4 result and hands it downstream with valid/ready.
// Optional watchdog: define RTU_ARB_TIMEOUT_EN to bound the BUSY wait.
module rtu_arbiter #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       req,
  input  logic [0:5][0:5][DATA_W-1:0]      tile_in0,
  input  logic [0:5][0:5][DATA_W-1:0]      tile_in1,
  output logic [1:0]                       ack,
  output logic                             rtu_start,
  output logic [0:5][0:5][DATA_W-1:0]      rtu_matrix_in,
  input  logic [0:3][0:3][DATA_W-1:0]      rtu_matrix_out,
  input  logic                             rtu_done,
  output logic                             res_valid,
  output logic                             res_id,
  output logic [0:3][0:3][DATA_W-1:0]      res_data,
  input  logic                             res_ready,
`ifdef RTU_ARB_TIMEOUT_EN
  output logic                             timeout_err,
`endif
  output logic                             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    OUT   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                        state_q;
  state_t                        state_d;
  logic                          ptr_q;
  logic                          grant_d;
  logic [0:5][0:5][DATA_W-1:0]   tile_q;

`ifdef RTU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;
  logic             tmo_fire;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Pick a requester: the pointer breaks ties, a lone request always wins.
  always_comb begin
    grant_d = 1'b0;
    if (req == 2'b11) begin
      grant_d = ptr_q;
    end else begin
      grant_d = req[1];
    end
  end

  // Next-state and handshake outputs; a request dropped before its ack
  // cancels the grant and returns to IDLE without starting the RTU.
  always_comb begin
    state_d   = state_q;
    ack       = 2'b00;
    rtu_start = 1'b0;
    res_valid = 1'b0;
`ifdef RTU_ARB_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rtu_done && (req != 2'b00)) begin
          state_d = START;
        end
      end
      START: begin
        if (req[res_id]) begin
          ack       = res_id ? 2'b10 : 2'b01;
          rtu_start = 1'b1;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (rtu_done) begin
          state_d = OUT;
`ifdef RTU_ARB_TIMEOUT_EN
        end else if (tmo_cnt_q == CNT_LIMIT) begin
          tmo_fire = 1'b1;
          state_d  = DRAIN;
`endif
        end
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!rtu_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, round-robin pointer, tile latch and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      res_id   <= 1'b0;
      tile_q   <= '0;
      res_data <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d == START)) begin
        tile_q <= grant_d ? tile_in1 : tile_in0;
        res_id <= grant_d;
      end
      if (rtu_start) begin
        ptr_q <= ~res_id;
      end
      if ((state_q == BUSY) && rtu_done) begin
        res_data <= rtu_matrix_out;
      end
    end
  end

`ifdef RTU_ARB_TIMEOUT_EN
  // Watchdog: count BUSY cycles from zero, raise a sticky error on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == START) begin
        tmo_cnt_q <= '0;
      end else if (state_q == BUSY) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (tmo_fire) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`endif

  assign rtu_matrix_in = tile_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rtu_arbiter.sv
// Directed testbench for rtu_arbiter with a behavioural RTU stub that
// applies the 4x4/6x6 Winograd output transform after a fixed latency.
// Define RTU_ARB_TIMEOUT_EN to also exercise the watchdog path.
`timescale 1ns/1ps
module tb_rtu_arbiter;

  localparam int DATA_W  = 32;
  localparam int RTU_LAT = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [1:0]                  req;
  logic [0:5][0:5][DATA_W-1:0] tile_in0;
  logic [0:5][0:5][DATA_W-1:0] tile_in1;
  logic [1:0]                  ack;
  logic                        rtu_start;
  logic [0:5][0:5][DATA_W-1:0] rtu_matrix_in;
  logic [0:3][0:3][DATA_W-1:0] rtu_matrix_out;
  logic                        rtu_done;
  logic                        res_valid;
  logic                        res_id;
  logic [0:3][0:3][DATA_W-1:0] res_data;
  logic                        res_ready;
  logic                        busy;
`ifdef RTU_ARB_TIMEOUT_EN
  logic                        timeout_err;
`endif

  int checks = 0;
  int errors = 0;
  int ackPulses = 0;
  int startPulses = 0;
  logic stubNeverDone = 1'b0;
  int rtuCnt = 0;
  int tailCnt = 0;

  rtu_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .tile_in0(tile_in0), .tile_in1(tile_in1),
    .ack(ack), .rtu_start(rtu_start),
    .rtu_matrix_in(rtu_matrix_in), .rtu_matrix_out(rtu_matrix_out),
    .rtu_done(rtu_done),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_ready(res_ready),
`ifdef RTU_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference transform Y = AT * M * A used by the RTU stub.
  function automatic logic [0:3][0:3][DATA_W-1:0] winoOut(input logic [0:5][0:5][DATA_W-1:0] m);
    int at [0:3][0:5];
    int t  [0:3][0:5];
    int acc;
    logic [0:3][0:3][DATA_W-1:0] y;
    at = '{'{1, 1, 1, 1, 1, 0}, '{0, 1, -1, 2, -2, 0},
           '{0, 1, 1, 4, 4, 0}, '{0, 1, -1, 8, -8, 1}};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++) begin
        acc = 0;
        for (int k = 0; k < 6; k++) acc += at[r][k] * $signed(m[k][c]);
        t[r][c] = acc;
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        for (int k = 0; k < 6; k++) acc += t[r][k] * at[c][k];
        y[r][c] = DATA_W'(acc);
      end
    return y;
  endfunction

  always_comb rtu_matrix_out = winoOut(rtu_matrix_in);

  // RTU stub: done rises RTU_LAT cycles after start, falls two cycles after the result handshake.
  always @(posedge clk) begin
    if (rst) begin
      rtuCnt   <= 0;
      tailCnt  <= 0;
      rtu_done <= 1'b0;
    end else if (rtu_start) begin
      rtuCnt   <= RTU_LAT;
      rtu_done <= 1'b0;
    end else if (rtuCnt != 0) begin
      rtuCnt <= rtuCnt - 1;
      if (rtuCnt == 1 && !stubNeverDone) rtu_done <= 1'b1;
    end else if (rtu_done && res_valid && res_ready) begin
      tailCnt <= 2;
    end else if (tailCnt != 0) begin
      tailCnt <= tailCnt - 1;
      if (tailCnt == 1) rtu_done <= 1'b0;
    end
  end

  // Count ack and start pulses seen at each rising edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (ack != 2'b00) ackPulses <= ackPulses + 1;
      if (rtu_start) startPulses <= startPulses + 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic rdy);
    req       = r;
    res_ready = rdy;
  endtask

  task automatic waitAck(output logic [1:0] seen, output int n);
    seen = 2'b00;
    n    = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (ack != 2'b00) begin
        seen = ack;
        break;
      end
    end
    checkOutput("ack_wait", 32'(seen != 2'b00), 32'd1);
  endtask

  task automatic waitValid(output int n);
    logic seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("valid_wait", 32'(seen), 32'd1);
  endtask

  task automatic waitIdle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("idle_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [1:0] seen;
    int n;
    int bad;
    int ackSeen;
    int ackBase;
    int startBase;
    int s [0:3];
    s = '{1, -1, 1, -1};

    rst = 1'b1;
    tile_in0 = '0;
    tile_in1 = '0;
    applyStimulus(2'b00, 1'b1);
    repeat (3) tick();
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_start", 32'(rtu_start), 32'd0);
    checkOutput("rst_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_id", 32'(res_id), 32'd0);
    checkOutput("rst_data", 32'(res_data != '0), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mat_in", 32'(rtu_matrix_in != '0), 32'd0);
`ifdef RTU_ARB_TIMEOUT_EN
    checkOutput("rst_tmo", 32'(timeout_err), 32'd0);
`endif
    rst = 1'b0;
    tick();

    $display("[TB] single request, zero tile");
    applyStimulus(2'b01, 1'b1);
    waitAck(seen, n);
    checkOutput("single_ack", 32'(seen), 32'd1);
    checkOutput("single_start", 32'(rtu_start), 32'd1);
    tick();
    applyStimulus(2'b00, 1'b1);
    checkOutput("single_ack_pulse", 32'(ack), 32'd0);
    checkOutput("single_start_pulse", 32'(rtu_start), 32'd0);
    checkOutput("single_busy", 32'(busy), 32'd1);
    waitValid(n);
    checkOutput("single_latency", 32'(n + 1), 32'(2 + RTU_LAT));
    checkOutput("single_id", 32'(res_id), 32'd0);
    checkOutput("single_data", 32'(res_data != '0), 32'd0);
    waitIdle();

    $display("[TB] transform path on requester 1");
    tile_in1[2][2] = 32'd1;
    applyStimulus(2'b10, 1'b1);
    waitAck(seen, n);
    checkOutput("xform_ack", 32'(seen), 32'd2);
    tick();
    applyStimulus(2'b00, 1'b1);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) tile_in1[i][j] = 32'd7;
    checkOutput("xform_latched_22", rtu_matrix_in[2][2], 32'd1);
    checkOutput("xform_latched_00", rtu_matrix_in[0][0], 32'd0);
    waitValid(n);
    checkOutput("xform_id", 32'(res_id), 32'd1);
    checkOutput("xform_01", res_data[0][1], 32'hFFFF_FFFF);
    checkOutput("xform_33", res_data[3][3], 32'd1);
    checkOutput("xform_00", res_data[0][0], 32'd1);
    checkOutput("xform_10", res_data[1][0], 32'hFFFF_FFFF);
    bad = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (res_data[i][j] !== 32'(s[i] * s[j])) bad++;
    checkOutput("xform_all", 32'(bad), 32'd0);
    waitIdle();

    $display("[TB] contention after reset");
    tile_in1 = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ackBase = ackPulses;
    applyStimulus(2'b11, 1'b1);
    for (int g = 0; g < 4; g++) begin
      waitAck(seen, n);
      checkOutput($sformatf("cont_grant%0d", g), 32'(seen), (g % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      checkOutput($sformatf("cont_pulse%0d", g), 32'(ack), 32'd0);
      if (g == 3) applyStimulus(2'b00, 1'b1);
    end
    waitIdle();
    checkOutput("cont_ack_count", 32'(ackPulses - ackBase), 32'd4);

    $display("[TB] backpressure");
    tile_in0[0][0] = 32'd5;
    applyStimulus(2'b01, 1'b0);
    waitAck(seen, n);
    checkOutput("bp_ack", 32'(seen), 32'd1);
    tick();
    applyStimulus(2'b10, 1'b0);
    waitValid(n);
    bad = 0;
    ackSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (!res_valid || res_id !== 1'b0 || res_data[0][0] !== 32'd5 || res_data[1][1] !== 32'd0) bad++;
      if (ack != 2'b00) ackSeen++;
      tick();
    end
    checkOutput("bp_stable", 32'(bad), 32'd0);
    checkOutput("bp_no_ack", 32'(ackSeen), 32'd0);
    applyStimulus(2'b10, 1'b1);
    waitAck(seen, n);
    checkOutput("bp_next_ack", 32'(seen), 32'd2);
    checkOutput("bp_ack_delay", 32'(n), 32'd5);
    checkOutput("bp_done_low", 32'(rtu_done), 32'd0);
    tick();
    applyStimulus(2'b00, 1'b1);
    waitIdle();

    $display("[TB] reset mid-BUSY");
    applyStimulus(2'b01, 1'b1);
    waitAck(seen, n);
    checkOutput("mid_ack", 32'(seen), 32'd1);
    tick();
    applyStimulus(2'b00, 1'b1);
    tick();
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_valid", 32'(res_valid), 32'd0);
    checkOutput("mid_mat_in", rtu_matrix_in[0][0], 32'd0);
    applyStimulus(2'b11, 1'b1);
    waitAck(seen, n);
    checkOutput("mid_ptr_reset", 32'(seen), 32'd1);
    tick();
    applyStimulus(2'b00, 1'b1);
    waitValid(n);
    waitIdle();
    applyStimulus(2'b10, 1'b1);
    waitAck(seen, n);
    checkOutput("mid_req10", 32'(seen), 32'd2);
    tick();
    applyStimulus(2'b00, 1'b1);
    waitValid(n);
    checkOutput("mid_req10_id", 32'(res_id), 32'd1);
    waitIdle();

    $display("[TB] withdrawn request");
    ackBase   = ackPulses;
    startBase = startPulses;
    applyStimulus(2'b01, 1'b1);
    tick();
    applyStimulus(2'b00, 1'b1);
    #1;
    checkOutput("wd_ack_now", 32'(ack), 32'd0);
    tick();
    tick();
    checkOutput("wd_busy", 32'(busy), 32'd0);
    checkOutput("wd_ack_count", 32'(ackPulses - ackBase), 32'd0);
    checkOutput("wd_start_count", 32'(startPulses - startBase), 32'd0);

`ifdef RTU_ARB_TIMEOUT_EN
    $display("[TB] watchdog");
    stubNeverDone = 1'b1;
    applyStimulus(2'b01, 1'b1);
    waitAck(seen, n);
    checkOutput("tmo_ack", 32'(seen), 32'd1);
    tick();
    applyStimulus(2'b00, 1'b1);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (res_valid) bad++;
      tick();
    end
    checkOutput("tmo_err_early", 32'(timeout_err), 32'd0);
    checkOutput("tmo_busy_early", 32'(busy), 32'd1);
    tick();
    checkOutput("tmo_err", 32'(timeout_err), 32'd1);
    if (res_valid) bad++;
    tick();
    if (res_valid) bad++;
    checkOutput("tmo_no_valid", 32'(bad), 32'd0);
    checkOutput("tmo_idle", 32'(busy), 32'd0);
    tick();
    checkOutput("tmo_sticky", 32'(timeout_err), 32'd1);
    stubNeverDone = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
